// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory bank: access size encodings, FSM states, data width.
// Alignment helpers serve both builds (DMEM_ALIGN_CHECK_EN defined or not).
package data_mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] align_off(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: align_off = off;
      SZ_HALF: align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational lane steering: byte-enable mask and replicated store data on the way in,
// lane extraction plus sign/zero extension on the way out.
module dmem_byte_lane
  import data_mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [3:0]        we_mask_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    we_mask_o = 4'b1111;
    wdata_o   = wdata_i;
    rdata_o   = rword_i;
    byte_v    = rword_i[8*off_i +: 8];
    half_v    = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_e'(size_i))
      SZ_BYTE: begin
        we_mask_o = 4'b0001 << off_i;
        wdata_o   = {4{wdata_i[7:0]}};
        rdata_o   = unsigned_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        we_mask_o = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        rdata_o   = unsigned_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressable 32-bit data memory with a fixed-latency IDLE/WAIT/RESP handshake.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned/reserved accesses with Err instead of masking.
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, uns_q, err_q;
  size_e               size_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                accept, commit;
  size_e               size_cap;
  logic [1:0]          off_cap;
  logic                err_cap;
  logic [3:0]          lane_mask, lane_we;
  logic [DATA_W-1:0]   lane_wdata, load_data, rword, sq_word;
  logic [7:0]          rword_lane [4];
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr_i[31:ADDR_W+2];

  assign accept = (state_q == ST_IDLE) && req_i && !srst_i;
  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !srst_i;

  always_comb begin
    size_cap = size_e'(size_i);
    off_cap  = addr_i[1:0];
    err_cap  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    err_cap  = is_misaligned(size_cap, addr_i[1:0]);
`else
    if (size_cap == SZ_RSVD) size_cap = SZ_WORD;
    off_cap  = align_off(size_cap, addr_i[1:0]);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req_i) begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
               else cnt_d = cnt_q - 4'd1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      write_q <= write_i;
      size_q  <= size_cap;
      uns_q   <= unsigned_i;
      off_q   <= off_cap;
      idx_q   <= addr_i[ADDR_W+1:2];
      wdata_q <= wdata_i;
      err_q   <= err_cap;
    end
  end

  dmem_byte_lane u_lane (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (off_q),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .we_mask_o  (lane_mask),
    .wdata_o    (lane_wdata),
    .rdata_o    (load_data)
  );

  assign lane_we = lane_mask & {4{commit && write_q && !err_q}};
  assign sq_word = 32'(idx_q) * 32'(idx_q);

  // Bytes never stored read back as their share of index*index, so the arrays need no preload.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0]       mem_q [DEPTH];
    logic [DEPTH-1:0] written_q = '0;
    logic [7:0]       rd_q;
    logic             rd_written_q;

    always_ff @(posedge clk_i) begin
      if (lane_we[gi]) begin
        mem_q[idx_q]     <= lane_wdata[gi*8 +: 8];
        written_q[idx_q] <= 1'b1;
      end
      if (commit) begin
        rd_q         <= mem_q[idx_q];
        rd_written_q <= written_q[idx_q];
      end
    end

    assign rword_lane[gi] = rd_written_q ? rd_q : sq_word[gi*8 +: 8];
  end

  assign rword = {rword_lane[3], rword_lane[2], rword_lane[1], rword_lane[0]};

  always_comb begin
    ready_o = (state_q == ST_IDLE);
    done_o  = (state_q == ST_RESP);
    err_o   = (state_q == ST_RESP) && err_q;
    rdata_o = '0;
    if ((state_q == ST_RESP) && !write_q && !err_q) rdata_o = load_data;
  end

endmodule
